// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU execution controller: FSM state encoding,
// ALU op codes and the bit positions of the fields in the 16-bit instruction.
package alu_exec_ctrl_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPERAND,
        ST_EXEC,
        ST_WRITE
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_LDI  = 3'b111;

    // instr = [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [6:0] imm7 (LDI only)
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 13;
    localparam int unsigned RD_MSB  = 12;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RS1_MSB = 9;
    localparam int unsigned RS1_LSB = 7;
    localparam int unsigned RS2_MSB = 6;
    localparam int unsigned RS2_LSB = 4;
    localparam int unsigned IMM_MSB = 6;
    localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/alu_exec_ctrl_regfile.sv
// alu_regfile: 8 x 16-bit register file, r0 hardwired to zero.
// Ports: clk/rst (async active-high), two combinational read ports
// (rd_addr0/rd_data0, rd_addr1/rd_data1), a combinational debug read port
// (dbg_addr/dbg_data) and one synchronous write port (wr_en/wr_addr/wr_data).
module alu_regfile
    import alu_exec_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data0 = (rd_addr0 == '0) ? '0 : regs[rd_addr0];
        rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
        dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: four-state controller (IDLE -> OPERAND -> EXEC -> WRITE)
// that sequences one instruction through an external combinational ALU.
// Ports: clk/rst (async active-high); instr_valid/instr_ready/instr handshake;
// alu_op/alu_in0/alu_in1 to the ALU and alu_out back; done (1-cycle pulse in
// WRITE), result/zero (last written-back value); dbg_addr/dbg_data debug read.
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_in0,
    output logic [DATA_W-1:0] alu_in1,
    input  logic [DATA_W-1:0] alu_out,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    logic [15:0]       instr_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [6:0]        imm_q;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] exec_value;

    always_comb begin
        op_q       = instr_q[OP_MSB:OP_LSB];
        rd_q       = instr_q[RD_MSB:RD_LSB];
        rs1_q      = instr_q[RS1_MSB:RS1_LSB];
        rs2_q      = instr_q[RS2_MSB:RS2_LSB];
        imm_q      = instr_q[IMM_MSB:IMM_LSB];
        exec_value = (op_q == OP_LDI) ? {9'b0, imm_q} : alu_out;
    end

    // The register write happens on the edge that leaves WRITE, so a reset
    // arriving any time before that edge drops the write entirely.
    alu_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_addr0 (rs1_q),
        .rd_data0 (rs1_data),
        .rd_addr1 (rs2_q),
        .rd_data1 (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (state == ST_WRITE),
        .wr_addr  (rd_q),
        .wr_data  (result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            instr_q     <= '0;
            instr_ready <= 1'b1;
            alu_op      <= '0;
            alu_in0     <= '0;
            alu_in1     <= '0;
            result      <= '0;
            zero        <= 1'b1;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q     <= instr;
                        alu_op      <= instr[OP_MSB:OP_LSB];
                        instr_ready <= 1'b0;
                        state       <= ST_OPERAND;
                    end
                end
                ST_OPERAND: begin
                    alu_in0 <= rs1_data;
                    alu_in1 <= rs2_data;
                    state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    // result/zero/done are set entering WRITE so they are
                    // visible together with the done pulse.
                    result <= exec_value;
                    zero   <= (exec_value == '0);
                    done   <= 1'b1;
                    state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
module tb_alu_exec_ctrl;
    import alu_exec_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [2:0]  alu_op;
    logic [15:0] alu_in0;
    logic [15:0] alu_in1;
    logic [15:0] alu_out;
    logic        done;
    logic [15:0] result;
    logic        zero;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int checks = 0;
    int failures = 0;
    logic [15:0] mreg [8];

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_op      (alu_op),
        .alu_in0     (alu_in0),
        .alu_in1     (alu_in1),
        .alu_out     (alu_out),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Downstream ALU; LDI output is junk so the immediate path is exercised.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_out = alu_in0 + alu_in1;
            OP_SUB:  alu_out = alu_in0 - alu_in1;
            OP_AND:  alu_out = alu_in0 & alu_in1;
            OP_OR:   alu_out = alu_in0 | alu_in1;
            OP_XOR:  alu_out = alu_in0 ^ alu_in1;
            OP_NOR:  alu_out = ~(alu_in0 | alu_in1);
            OP_XNOR: alu_out = ~(alu_in0 ^ alu_in1);
            default: alu_out = 16'hDEAD;
        endcase
    end

    typedef struct {
        logic [15:0] ins;
        logic [15:0] exp_result;
        logic        exp_zero;
        logic [15:0] exp_reg;
    } vec_t;

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [15:0] mk_ldi(input logic [2:0] rd, input logic [6:0] imm);
        return {OP_LDI, rd, 3'b000, imm};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (instr_ready !== 1'b1) chk("ready_timeout", {15'b0, instr_ready}, 16'h0001);
    endtask

    // Called at a negedge; returns at the negedge after writeback.
    task automatic run(input vec_t v);
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        op  = v.ins[15:13];
        rd  = v.ins[12:10];
        rs1 = v.ins[9:7];
        rs2 = v.ins[6:4];
        wait_ready();
        dbg_addr    = rd;
        instr       = v.ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("operand_ready", {15'b0, instr_ready}, 16'h0000);
        chk("operand_alu_op", {13'b0, alu_op}, {13'b0, op});
        chk("operand_done", {15'b0, done}, 16'h0000);
        @(negedge clk);
        chk("exec_ready", {15'b0, instr_ready}, 16'h0000);
        chk("exec_done", {15'b0, done}, 16'h0000);
        if (op != OP_LDI) begin
            chk("exec_in0", alu_in0, mreg[rs1]);
            chk("exec_in1", alu_in1, mreg[rs2]);
        end
        @(negedge clk);
        chk("write_done", {15'b0, done}, 16'h0001);
        chk("write_ready", {15'b0, instr_ready}, 16'h0000);
        chk("write_result", result, v.exp_result);
        chk("write_zero", {15'b0, zero}, {15'b0, v.exp_zero});
        @(negedge clk);
        chk("after_done", {15'b0, done}, 16'h0000);
        chk("after_ready", {15'b0, instr_ready}, 16'h0001);
        chk("after_reg", dbg_data, v.exp_reg);
        if (rd != 3'd0) mreg[rd] = v.exp_reg;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, {15'b0, instr_ready}, 16'h0001);
        chk({tag, "_done"}, {15'b0, done}, 16'h0000);
        chk({tag, "_result"}, result, 16'h0000);
        chk({tag, "_zero"}, {15'b0, zero}, 16'h0001);
        chk({tag, "_alu_op"}, {13'b0, alu_op}, 16'h0000);
        chk({tag, "_in0"}, alu_in0, 16'h0000);
        chk({tag, "_in1"}, alu_in1, 16'h0000);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1 chk({tag, "_reg"}, dbg_data, 16'h0000);
        end
    endtask

    initial begin
        vec_t vecs[13];
        int acc;
        int dn;
        for (int r = 0; r < 8; r++) mreg[r] = '0;

        vecs[0]  = '{mk_ldi(3'd1, 7'h05),            16'h0005, 1'b0, 16'h0005};
        vecs[1]  = '{mk_ldi(3'd2, 7'h03),            16'h0003, 1'b0, 16'h0003};
        vecs[2]  = '{mk(OP_ADD, 3'd3, 3'd1, 3'd2),   16'h0008, 1'b0, 16'h0008};
        vecs[3]  = '{mk(OP_SUB, 3'd4, 3'd2, 3'd1),   16'hFFFE, 1'b0, 16'hFFFE};
        vecs[4]  = '{mk(OP_ADD, 3'd5, 3'd4, 3'd4),   16'hFFFC, 1'b0, 16'hFFFC};
        vecs[5]  = '{mk(OP_XOR, 3'd6, 3'd1, 3'd1),   16'h0000, 1'b1, 16'h0000};
        vecs[6]  = '{mk(OP_ADD, 3'd1, 3'd1, 3'd2),   16'h0008, 1'b0, 16'h0008};
        vecs[7]  = '{mk(OP_AND, 3'd7, 3'd4, 3'd2),   16'h0002, 1'b0, 16'h0002};
        vecs[8]  = '{mk(OP_OR,  3'd7, 3'd1, 3'd2),   16'h000B, 1'b0, 16'h000B};
        vecs[9]  = '{mk(OP_NOR, 3'd7, 3'd1, 3'd2),   16'hFFF4, 1'b0, 16'hFFF4};
        vecs[10] = '{mk(OP_XNOR, 3'd7, 3'd2, 3'd2),  16'hFFFF, 1'b0, 16'hFFFF};
        vecs[11] = '{mk_ldi(3'd0, 7'h7F),            16'h007F, 1'b0, 16'h0000};
        vecs[12] = '{mk(OP_ADD, 3'd6, 3'd0, 3'd5),   16'hFFFC, 1'b0, 16'hFFFC};

        repeat (3) @(negedge clk);
        check_reset_state("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        for (int i = 0; i < 13; i++) run(vecs[i]);

        // instr_valid held for 10 cycles: accepted every 4th cycle only.
        acc = 0;
        dn = 0;
        instr = mk_ldi(3'd6, 7'h11);
        for (int i = 0; i < 14; i++) begin
            instr_valid = (i < 10);
            if (instr_valid && instr_ready) acc++;
            if (done) dn++;
            @(posedge clk);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("burst_accepted", 16'(acc), 16'd3);
        chk("burst_done", 16'(dn), 16'd3);
        dbg_addr = 3'd6;
        #1 chk("burst_r6", dbg_data, 16'h0011);
        mreg[6] = 16'h0011;

        // Reset during EXEC of ADD r7,r1,r2 aborts the instruction.
        wait_ready();
        dbg_addr    = 3'd7;
        instr       = mk(OP_ADD, 3'd7, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_done", {15'b0, done}, 16'h0000);
        rst = 1'b1;
        #1 chk("abort_rst_done", {15'b0, done}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("abort_no_done", 16'(dn), 16'd0);
        chk("abort_r7", dbg_data, 16'h0000);
        chk("abort_ready", {15'b0, instr_ready}, 16'h0001);
        chk("abort_zero", {15'b0, zero}, 16'h0001);
        chk("abort_result", result, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 instr_valid  input  1  instruction word is present.
REQ-005 instr_ready  output  1  block can accept an instruction.
REQ-006 instr  input  16  [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [6:0] imm7 (op 3'b111 only).
REQ-007 alu_op  output  3  operation code sent to the downstream ALU.
REQ-008 alu_in0 / alu_in1  output  16 each  ALU operands (rs1 value / rs2 value).
REQ-009 alu_out  input  16  combinational ALU result.
REQ-010 done  output  1  one-cycle pulse on writeback.
REQ-011 result  output  16  last written-back value.
REQ-012 zero  output  1  result == 0 at last writeback.
REQ-013 dbg_addr  input  3 / dbg_data  output  16  combinational register-file read port.

Function
REQ-014 FSM states SHALL be IDLE, OPERAND, EXEC, WRITE.
REQ-015 IDLE: instr_ready=1. On instr_valid&instr_ready at an edge, latch instr and go to OPERAND.
REQ-016 OPERAND: instr_ready=0. Read rs1/rs2 into operand registers and drive alu_op from the latched op. Go to EXEC next cycle.
REQ-017 EXEC: hold alu_op/alu_in0/alu_in1 stable and capture alu_out into the result register. For op 3'b111, capture {9'b0, imm7} instead. Go to WRITE.
REQ-018 WRITE: write the result register to rd, update zero, pulse done for exactly this cycle, return to IDLE.
REQ-019 Latency: handshake at edge N -> done high during cycle N+3. Throughput: one instruction per 4 cycles.
REQ-020 instr_valid while instr_ready=0 SHALL be ignored. No queuing, no side effects.
REQ-021 Register file: 8 x 16 bits. r0 SHALL read 0 always. Writes to r0 are discarded, but done, result and zero still update.
REQ-022 Operands SHALL be sampled in OPERAND, so rd==rs1 or rd==rs2 uses pre-write values.
REQ-023 Arithmetic wraps modulo 2^16. No carry/overflow flag.
REQ-024 alu_in0/alu_in1 SHALL hold their last values outside OPERAND/EXEC. alu_op SHALL hold the last latched op.
REQ-025 dbg_data SHALL reflect a WRITE in the cycle after that edge.

Reset
REQ-026 rst SHALL force IDLE, all registers r1..r7 = 0, result=0, zero=1, done=0, alu_op=0, alu_in0=alu_in1=0, and instr_ready=1 after release.
REQ-027 rst asserted mid-operation SHALL abort the instruction with no register write and no done pulse.

Structure
REQ-028 A shared package SHALL hold the state enumeration, the op code constants (ADD=000 .. XNOR=110, LDI=111), and the instr field bit positions.
REQ-029 The register file SHALL be one sub-module, alu_regfile: 2 read ports, 1 debug read port, 1 write port, r0 hardwired zero.
REQ-030 The bench SHALL instantiate the existing ALU on alu_op/alu_in0/alu_in1/alu_out.

Verification
REQ-031 LDI r1,0x05 then LDI r2,0x03, then ADD r3,r1,r2 -> r3=0x0008, zero=0, done at N+3 for each instruction.
REQ-032 SUB r4,r2,r1 (3-5) -> r4=0xFFFE. ADD r5,r4,r4 -> 0xFFFC (wrap).
REQ-033 XOR r6,r1,r1 -> r6=0x0000, zero=1. ADD r1,r1,r2 -> r1=0x0008 (old r1 used).
REQ-034 LDI r0,0x7F -> dbg r0 reads 0x0000, result=0x007F, done pulses.
REQ-035 instr_valid held high for 10 cycles -> exactly 3 instructions accepted, instr_ready low in OPERAND/EXEC/WRITE.
REQ-036 rst asserted in EXEC of ADD r7,r1,r2 -> r7=0, no done, state IDLE, zero=1.
